irq_controller: RTL
===================

# irq_controller

Memory-mapped interrupt controller that merges up to eight peripheral interrupt requests onto one processor interrupt line. It sits on the shared 8-bit data/address bus beside the RAM, timer and I/O drivers, and drives one bit of the processor's raise/ack interrupt pair. Pending and mask registers are software-visible, and arbitration is round-robin. The block holds one interrupt in service at a time and needs an explicit end-of-interrupt write before it raises the next.

## Interface
- BASE_ADDR, 8'hA0: bus base address; four registers at BASE_ADDR+0..+3
- NUM_SRC, 8: number of request inputs, legal range 1..8

- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-low reset
- BUS_DATA  inout  8  shared data bus; tristated unless this block is reading out
- BUS_ADDR  in  8  shared address bus
- BUS_WE  in  1  bus write enable
- IRQ_IN  in  NUM_SRC  peripheral requests; a rising edge requests service
- CPU_IRQ_RAISE  out  1  to the processor's interrupt raise input
- CPU_IRQ_ACK  in  1  from the processor's interrupt ack output, one-cycle pulse

## Operation
- Registers (offset: name, access, reset value):
  - +0: PEND, read / write-1-to-clear, 0x00
  - +1: MASK, read/write, 0x00; 1 = enabled
  - +2: ISR_ID, read-only, 0x00; bit7 = in service, bits[2:0] = source ID
  - +3: EOI, write-only; any value ends service. Reads of EOI return 0x00.
- Bits at or above NUM_SRC in PEND and MASK always read 0 and ignore writes.
- IRQ_IN is registered once. A rising edge on bit i sets PEND[i].
  - If an edge and a W1C of the same bit happen in the same cycle, the set wins.
- Eligible set = PEND & MASK. Arbitration is round-robin: search starts at pointer RR and wraps modulo NUM_SRC. The first eligible index wins.
- FSM states: IDLE, RAISE, SERVICE.
  - IDLE: if the eligible set is non-zero, latch the winner into GRANT, go to RAISE, and assert CPU_IRQ_RAISE.
  - RAISE: hold CPU_IRQ_RAISE high until CPU_IRQ_ACK. On ack:
    - deassert raise
    - clear PEND[GRANT]
    - ISR_ID <= {1'b1, 4'b0, GRANT}
    - go to SERVICE
  - A mask clear or W1C of PEND[GRANT] during RAISE does not retract the raise; the ack still completes normally.
  - SERVICE: new edges keep accumulating in PEND; nothing is raised. A write to EOI sets RR <= (GRANT+1) mod NUM_SRC, clears ISR_ID to 0x00, and returns to IDLE.
  - EOI writes in IDLE or RAISE are ignored.
- An ack outside RAISE is ignored.
- Bus read: on each clock edge, if BUS_ADDR is in range and BUS_WE=0, register the addressed value and set the output enable; otherwise clear the output enable. BUS_DATA = enable ? value : 'z.
- Bus write: when BUS_WE=1 and BUS_ADDR is in range, the addressed register updates at the clock edge.
- Asserting RESET at any time, including mid-service, returns everything to reset values:
  - state IDLE, RR=0, GRANT=0
  - CPU_IRQ_RAISE=0, output enable 0
  - all registers at reset values

## Timing
- IRQ_IN edge sampled at edge k: PEND bit set at k+1. If the bit is enabled and the FSM is IDLE, CPU_IRQ_RAISE is high after k+2.
- Ack sampled at edge m: CPU_IRQ_RAISE is low and ISR_ID is valid after m.
- EOI written at edge n: state is IDLE after n. If another source is eligible, raise is high again after n+1.
- Read latency is one cycle: data drives the bus in the cycle after the address is presented.
- Minimum gap between consecutive raises is two cycles: the EOI cycle plus the IDLE evaluation.

## Structure
- Package irq_ctrl_pkg holds:
  - the state enum (IDLE, RAISE, SERVICE)
  - register offset constants OFF_PEND=0, OFF_MASK=1, OFF_ID=2, OFF_EOI=3
  - constant MAX_SRC=8
- Sub-module rr_arbiter: inputs are the eligible vector and RR; outputs are winner index and a valid flag. It is purely combinational. The top level holds all state.

## Test plan
- MASK=0x05. Pulse IRQ_IN[2] -> raise high 2 cycles later. Ack -> ISR_ID=0x82, PEND=0x00. EOI -> ISR_ID=0x00.
- MASK=0xFF, RR=0. Pulse bits 1 and 5 together -> grant 1. Ack, EOI -> grant 5. Ack, EOI. Pulse 1 and 5 again -> grant 1 (RR=6 wraps).
- MASK=0x00. Pulse IRQ_IN[3] -> PEND=0x08, no raise. Write MASK=0x08 -> raise within 1 cycle after the write edge.
- In SERVICE for source 0, pulse IRQ_IN[4] -> no raise until EOI. Raise follows 1 cycle after the EOI edge.
- Edge on bit 6 in the same cycle as a W1C of 0x40 -> PEND[6]=1.
- Assert RESET during RAISE -> raise=0, PEND=0x00, MASK=0x00, BUS_DATA high-Z, no spurious raise after release.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the memory-mapped interrupt controller.
package irq_ctrl_pkg;

    localparam int unsigned MAX_SRC = 8;

    localparam logic [1:0] OFF_PEND = 2'd0;
    localparam logic [1:0] OFF_MASK = 2'd1;
    localparam logic [1:0] OFF_ID   = 2'd2;
    localparam logic [1:0] OFF_EOI  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        RAISE,
        SERVICE
    } irq_state_t;

endpackage

// File: rtl/irq_controller_rr_arbiter.sv
// Combinational round-robin picker: scans the eligible vector starting at the
// pointer, wrapping at NUM_SRC, and reports the first set index.
module rr_arbiter
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC = MAX_SRC
) (
    input  logic [MAX_SRC-1:0] i_elig,
    input  logic [2:0]         i_rr,
    output logic [2:0]         o_winner,
    output logic               o_valid
);

    logic [2:0] w_idx;

    // First eligible index at or after the pointer, modulo NUM_SRC
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_idx    = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            w_idx = 3'((32'(i_rr) + i) % NUM_SRC);
            if (!o_valid && i_elig[w_idx]) begin
                o_valid  = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: up to eight edge-triggered requests, software-visible
// pending/mask registers, round-robin arbitration and a raise/ack/EOI handshake
// holding a single interrupt in service at a time.
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR = 8'hA0,
    parameter int unsigned NUM_SRC   = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    inout  wire  [7:0]         BUS_DATA,
    input  logic [7:0]         BUS_ADDR,
    input  logic               BUS_WE,
    input  logic [NUM_SRC-1:0] IRQ_IN,
    output logic               CPU_IRQ_RAISE,
    input  logic               CPU_IRQ_ACK
);

    localparam logic [7:0] SRC_MASK = 8'((1 << NUM_SRC) - 1);

    irq_state_t r_state;
    irq_state_t w_next;

    logic [7:0] r_irq_s;
    logic [7:0] r_irq_d;
    logic [7:0] r_pend;
    logic [7:0] r_mask;
    logic [7:0] r_isr;
    logic [2:0] r_grant;
    logic [2:0] r_rr;
    logic [7:0] r_rd_data;
    logic       r_rd_oe;

    logic [7:0] w_irq;
    logic [7:0] w_edge;
    logic [7:0] w_elig;
    logic [7:0] w_off;
    logic       w_hit;
    logic       w_wr;
    logic       w_rd;
    logic       w_wr_pend;
    logic       w_wr_mask;
    logic       w_wr_eoi;
    logic [7:0] w_wdata;
    logic [7:0] w_pend_clr;
    logic [7:0] w_rd_val;
    logic [2:0] w_winner;
    logic       w_valid;
    logic       w_take;
    logic       w_ack;
    logic       w_eoi;

    // Zero-extend the request inputs to the full register width
    always_comb begin
        w_irq = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            w_irq[i] = IRQ_IN[i];
        end
    end

    assign w_edge  = r_irq_s & ~r_irq_d;
    assign w_elig  = r_pend & r_mask;

    // Subtracting the base keeps the range test correct even near 8'hFF
    assign w_off     = BUS_ADDR - BASE_ADDR;
    assign w_hit     = (w_off < 8'd4);
    assign w_wr      = BUS_WE & w_hit;
    assign w_rd      = ~BUS_WE & w_hit;
    assign w_wr_pend = w_wr & (w_off[1:0] == OFF_PEND);
    assign w_wr_mask = w_wr & (w_off[1:0] == OFF_MASK);
    assign w_wr_eoi  = w_wr & (w_off[1:0] == OFF_EOI);
    assign w_wdata   = BUS_DATA;

    assign BUS_DATA      = r_rd_oe ? r_rd_data : 'z;
    assign CPU_IRQ_RAISE = (r_state == RAISE);

    rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_arb (
        .i_elig   (w_elig),
        .i_rr     (r_rr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic and the one-cycle event strobes that drive the datapath
    always_comb begin
        w_next = r_state;
        w_take = 1'b0;
        w_ack  = 1'b0;
        w_eoi  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_next = RAISE;
                    w_take = 1'b1;
                end
            end
            RAISE: begin
                if (CPU_IRQ_ACK) begin
                    w_next = SERVICE;
                    w_ack  = 1'b1;
                end
            end
            SERVICE: begin
                if (w_wr_eoi) begin
                    w_next = IDLE;
                    w_eoi  = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Two-stage request sampling for rising-edge detection
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_irq_s <= '0;
            r_irq_d <= '0;
        end else begin
            r_irq_s <= w_irq;
            r_irq_d <= r_irq_s;
        end
    end

    // Clear sources for PEND: software W1C plus the acknowledged grant
    always_comb begin
        w_pend_clr = '0;
        if (w_wr_pend) w_pend_clr = w_wdata;
        if (w_ack)     w_pend_clr[r_grant] = 1'b1;
    end

    // Pending and mask registers; a new edge overrides any same-cycle clear
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_pend <= '0;
            r_mask <= '0;
        end else begin
            r_pend <= ((r_pend & ~w_pend_clr) | w_edge) & SRC_MASK;
            if (w_wr_mask) r_mask <= w_wdata & SRC_MASK;
        end
    end

    // Grant, round-robin pointer and in-service ID bookkeeping
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_grant <= '0;
            r_rr    <= '0;
            r_isr   <= '0;
        end else begin
            if (w_take) r_grant <= w_winner;
            if (w_ack)  r_isr   <= {1'b1, 4'b0000, r_grant};
            if (w_eoi) begin
                r_isr <= '0;
                r_rr  <= (32'(r_grant) == NUM_SRC - 1) ? 3'd0 : r_grant + 3'd1;
            end
        end
    end

    // Read-data mux for the addressed register
    always_comb begin
        w_rd_val = '0;
        unique case (w_off[1:0])
            OFF_PEND: w_rd_val = r_pend;
            OFF_MASK: w_rd_val = r_mask;
            OFF_ID:   w_rd_val = r_isr;
            OFF_EOI:  w_rd_val = '0;
            default:  w_rd_val = '0;
        endcase
    end

    // Registered read port: data and bus enable appear one cycle after address
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rd_oe   <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_oe <= w_rd;
            if (w_rd) r_rd_data <= w_rd_val;
        end
    end

endmodule
